// File: rtl/alu_ctrl_pkg.sv
// Shared constants and decoded-instruction bundle for the ALU control decode stage.
package alu_ctrl_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned IMM_W  = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  localparam logic [ALU_W-1:0] ALU_AND  = 3'b000;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLL  = 3'b010;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_MUL  = 3'b101;
  localparam logic [ALU_W-1:0] ALU_ADDI = 3'b110;
  localparam logic [ALU_W-1:0] ALU_SRAI = 3'b111;

  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;

  localparam logic [F7_W-1:0] F7_BASE   = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT    = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MULDIV = 7'b0000001;

  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_XOR = 3'b100;
  localparam logic [F3_W-1:0] F3_SR  = 3'b101;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic             alu_src;
    logic             reg_write;
    logic             illegal;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [IMM_W-1:0] imm;
  } dec_bundle_t;

endpackage

// File: rtl/alu_ctrl_lut.sv
// Purely combinational RV32 subset decode: instruction word to ALU control bundle.
module alu_ctrl_lut
  import alu_ctrl_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output dec_bundle_t       dec
);

  logic [OP_W-1:0]  opcode;
  logic [F3_W-1:0]  funct3;
  logic [F7_W-1:0]  funct7;
  logic             legal;
  logic             itype;
  logic [ALU_W-1:0] code;
  logic [IMM_W-1:0] imm;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Classify the instruction; anything unmatched stays illegal with a zero code.
  always_comb begin
    legal = 1'b0;
    itype = 1'b0;
    code  = ALU_AND;
    imm   = '0;
    case (opcode)
      OP_RTYPE: begin
        case ({funct7, funct3})
          {F7_BASE, F3_AND}:   begin legal = 1'b1; code = ALU_AND; end
          {F7_BASE, F3_XOR}:   begin legal = 1'b1; code = ALU_XOR; end
          {F7_BASE, F3_SLL}:   begin legal = 1'b1; code = ALU_SLL; end
          {F7_BASE, F3_ADD}:   begin legal = 1'b1; code = ALU_ADD; end
          {F7_ALT, F3_ADD}:    begin legal = 1'b1; code = ALU_SUB; end
          {F7_MULDIV, F3_ADD}: begin legal = 1'b1; code = ALU_MUL; end
          default: ;
        endcase
      end
      OP_ITYPE: begin
        if (funct3 == F3_ADD) begin
          legal = 1'b1;
          itype = 1'b1;
          code  = ALU_ADDI;
          imm   = IMM_W'($signed(inst[31:20]));
        end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
          legal = 1'b1;
          itype = 1'b1;
          code  = ALU_SRAI;
          imm   = IMM_W'(inst[24:20]);
        end
      end
      default: ;
    endcase
  end

  // Register indices pass through raw; I-type has no rs2 operand.
  always_comb begin
    dec           = '0;
    dec.alu_ctrl  = code;
    dec.alu_src   = itype;
    dec.illegal   = ~legal;
    dec.reg_write = legal & (|inst[11:7]);
    dec.rs1       = inst[19:15];
    dec.rs2       = itype ? '0 : inst[24:20];
    dec.rd        = inst[11:7];
    dec.imm       = imm;
  end

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// Registered ID stage: decodes one instruction behind a valid/ready handshake with flush.
// Optional ALU_DECODE_PERF_EN adds decoded/illegal load counters.
module alu_ctrl_decode_stage
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [2:0]      ALUCtrl_o,
  output logic            ALUSrc_o,
  output logic            RegWrite_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
`ifdef ALU_DECODE_PERF_EN
  ,
  output logic [31:0]     decoded_cnt_o,
  output logic [31:0]     illegal_cnt_o
`endif
);

  dec_bundle_t dec;
  logic        load;

  alu_ctrl_lut u_lut (
    .inst (INST_W'(inst_i)),
    .dec  (dec)
  );

  assign ready_o = ~valid_o | ready_i;
  assign load    = valid_i & ready_o & ~flush_i;

  // Output register: flush wins, then load, then drain on transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o    <= 1'b0;
      ALUCtrl_o  <= '0;
      ALUSrc_o   <= 1'b0;
      RegWrite_o <= 1'b0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      imm_o      <= '0;
      illegal_o  <= 1'b0;
    end else if (flush_i) begin
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      illegal_o  <= 1'b0;
    end else if (load) begin
      valid_o    <= 1'b1;
      ALUCtrl_o  <= dec.alu_ctrl;
      ALUSrc_o   <= dec.alu_src;
      RegWrite_o <= dec.reg_write;
      rs1_o      <= dec.rs1;
      rs2_o      <= dec.rs2;
      rd_o       <= dec.rd;
      imm_o      <= XLEN'(dec.imm);
      illegal_o  <= dec.illegal;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifdef ALU_DECODE_PERF_EN
  // Load counters; flush already suppresses load so it blocks the count too.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      decoded_cnt_o <= '0;
      illegal_cnt_o <= '0;
    end else if (load) begin
      if (dec.illegal) illegal_cnt_o <= illegal_cnt_o + 32'd1;
      else             decoded_cnt_o <= decoded_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Scoreboard bench for alu_ctrl_decode_stage: table-driven reference decode, random stimulus.
module tb_alu_ctrl_decode_stage;

  logic        clk, rst_i;
  logic [31:0] inst_i;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [2:0]  ALUCtrl_o;
  logic        ALUSrc_o, RegWrite_o, illegal_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
`ifdef ALU_DECODE_PERF_EN
  logic [31:0] decoded_cnt, illegal_cnt;
  int unsigned exp_dec, exp_ill;
`endif

  alu_ctrl_decode_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .ALUCtrl_o(ALUCtrl_o),
    .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .imm_o(imm_o), .illegal_o(illegal_o)
`ifdef ALU_DECODE_PERF_EN
    , .decoded_cnt_o(decoded_cnt), .illegal_cnt_o(illegal_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7; logic chk7; logic [2:0] code; logic itype;
  } rule_t;

  typedef struct {
    logic [2:0] ctrl; logic src; logic rw; logic ill;
    logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd; logic [31:0] imm;
  } exp_t;

  rule_t rules [8];
  exp_t  q [$];
  int    checks = 0;
  int    errors = 0;
  logic  flushed = 1'b0;
  logic  mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: search the supported-instruction table.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.ctrl = 3'd0; e.src = 1'b0; e.rw = 1'b0; e.ill = 1'b1; e.imm = 32'd0;
    for (int k = 0; k < 8; k++) begin
      if (i[6:0] == rules[k].op && i[14:12] == rules[k].f3 &&
          (!rules[k].chk7 || i[31:25] == rules[k].f7)) begin
        e.ill  = 1'b0;
        e.ctrl = rules[k].code;
        e.src  = rules[k].itype;
        e.rw   = (i[11:7] != 5'd0);
        if (rules[k].itype) e.rs2 = 5'd0;
        if (rules[k].code == 3'd6) e.imm = {{20{i[31]}}, i[31:20]};
        if (rules[k].code == 3'd7) e.imm = {27'd0, i[24:20]};
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] i;
    int k;
    k = int'($urandom_range(0, 9));
    i = $urandom;
    if (k < 8) begin
      i[6:0] = rules[k].op;
      i[14:12] = rules[k].f3;
      if (rules[k].chk7) i[31:25] = rules[k].f7;
      if ($urandom_range(0, 7) == 0) i[11:7] = 5'd0;
    end else if (k == 9) begin
      i[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
    end
    return i;
  endfunction

  // One clock: drive at posedge+2, model the edge, return at next posedge+2.
  task automatic cycle(input logic [31:0] inst, input logic v, input logic r, input logic f,
                       output logic acc);
    logic m_ready;
    inst_i = inst; valid_i = v; flush_i = f; ready_i = f ? 1'b0 : r;
    m_ready = (q.size() == 0) || ready_i;
    acc = valid_i & m_ready & ~flush_i;
    @(posedge clk);
    if (flush_i) begin
      q.delete();
      flushed = 1'b1;
    end else if (acc) begin
      q.push_back(ref_decode(inst));
      flushed = 1'b0;
`ifdef ALU_DECODE_PERF_EN
      if (ref_decode(inst).ill) exp_ill++; else exp_dec++;
`endif
    end
    #2;
  endtask

  task automatic reset_mid_cycle();
    rst_i = 1'b1;
    q.delete();
    flushed = 1'b0;
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd1);
    check("rst_ALUCtrl_o", 32'(ALUCtrl_o), 32'd0);
    check("rst_RegWrite_o", 32'(RegWrite_o), 32'd0);
    check("rst_rd_o", 32'(rd_o), 32'd0);
    check("rst_imm_o", imm_o, 32'd0);
    check("rst_illegal_o", 32'(illegal_o), 32'd0);
`ifdef ALU_DECODE_PERF_EN
    exp_dec = 0; exp_ill = 0;
    check("rst_decoded_cnt", decoded_cnt, 32'd0);
    check("rst_illegal_cnt", illegal_cnt, 32'd0);
`endif
    @(posedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  // Monitor: compare held outputs against the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    if (!rst_i && mon_en) begin
      exp_t e;
      check("valid_o", 32'(valid_o), 32'(q.size() != 0));
      check("ready_o", 32'(ready_o), 32'((q.size() == 0) || ready_i));
      if (q.size() != 0 && valid_o) begin
        e = q[0];
        check("ALUCtrl_o", 32'(ALUCtrl_o), 32'(e.ctrl));
        check("ALUSrc_o", 32'(ALUSrc_o), 32'(e.src));
        check("RegWrite_o", 32'(RegWrite_o), 32'(e.rw));
        check("illegal_o", 32'(illegal_o), 32'(e.ill));
        check("rs1_o", 32'(rs1_o), 32'(e.rs1));
        check("rs2_o", 32'(rs2_o), 32'(e.rs2));
        check("rd_o", 32'(rd_o), 32'(e.rd));
        check("imm_o", imm_o, e.imm);
        if (ready_i) void'(q.pop_front());
      end else if (flushed) begin
        check("flush_RegWrite_o", 32'(RegWrite_o), 32'd0);
        check("flush_illegal_o", 32'(illegal_o), 32'd0);
      end
    end
  end

  initial begin
    logic acc;
    logic pend;
    logic [31:0] cur;
    rules = '{
      '{7'b0110011, 3'b111, 7'b0000000, 1'b1, 3'd0, 1'b0},
      '{7'b0110011, 3'b100, 7'b0000000, 1'b1, 3'd1, 1'b0},
      '{7'b0110011, 3'b001, 7'b0000000, 1'b1, 3'd2, 1'b0},
      '{7'b0110011, 3'b000, 7'b0000000, 1'b1, 3'd3, 1'b0},
      '{7'b0110011, 3'b000, 7'b0100000, 1'b1, 3'd4, 1'b0},
      '{7'b0110011, 3'b000, 7'b0000001, 1'b1, 3'd5, 1'b0},
      '{7'b0010011, 3'b000, 7'b0000000, 1'b0, 3'd6, 1'b1},
      '{7'b0010011, 3'b101, 7'b0100000, 1'b1, 3'd7, 1'b1}
    };
`ifdef ALU_DECODE_PERF_EN
    exp_dec = 0; exp_ill = 0;
`endif
    rst_i = 1'b1; inst_i = '0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    @(posedge clk);
    #2;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    check("reset_ALUCtrl_o", 32'(ALUCtrl_o), 32'd0);
    check("reset_imm_o", imm_o, 32'd0);
    rst_i = 1'b0;
    mon_en = 1'b1;

    cycle(32'h002081B3, 1'b1, 1'b1, 1'b0, acc);
    check("add_ALUCtrl", 32'(ALUCtrl_o), 32'b011);
    check("add_ALUSrc", 32'(ALUSrc_o), 32'd0);
    check("add_RegWrite", 32'(RegWrite_o), 32'd1);
    check("add_rs1", 32'(rs1_o), 32'd1);
    check("add_rs2", 32'(rs2_o), 32'd2);
    check("add_rd", 32'(rd_o), 32'd3);
    check("add_valid", 32'(valid_o), 32'd1);
    cycle(32'h402081B3, 1'b1, 1'b1, 1'b0, acc);
    check("sub_ALUCtrl", 32'(ALUCtrl_o), 32'b100);
    cycle(32'h022081B3, 1'b1, 1'b1, 1'b0, acc);
    check("mul_ALUCtrl", 32'(ALUCtrl_o), 32'b101);
    cycle(32'hFFF00293, 1'b1, 1'b1, 1'b0, acc);
    check("addi_ALUCtrl", 32'(ALUCtrl_o), 32'b110);
    check("addi_ALUSrc", 32'(ALUSrc_o), 32'd1);
    check("addi_imm", imm_o, 32'hFFFFFFFF);
    check("addi_rd", 32'(rd_o), 32'd5);
    cycle(32'h4032D313, 1'b1, 1'b1, 1'b0, acc);
    check("srai_ALUCtrl", 32'(ALUCtrl_o), 32'b111);
    check("srai_imm", imm_o, 32'h00000003);
    check("srai_rs2", 32'(rs2_o), 32'd0);
    cycle(32'h0000707F, 1'b1, 1'b1, 1'b0, acc);
    check("ill_illegal", 32'(illegal_o), 32'd1);
    check("ill_RegWrite", 32'(RegWrite_o), 32'd0);
    check("ill_valid", 32'(valid_o), 32'd1);
    check("ill_ALUCtrl", 32'(ALUCtrl_o), 32'd0);
    cycle(32'h00000013, 1'b1, 1'b1, 1'b0, acc);
    check("nop_RegWrite", 32'(RegWrite_o), 32'd0);
    check("nop_illegal", 32'(illegal_o), 32'd0);

    cycle(32'h002081B3, 1'b1, 1'b1, 1'b0, acc);
    for (int s = 0; s < 3; s++) begin
      cycle(32'h402081B3, 1'b1, 1'b0, 1'b0, acc);
      check("stall_ready_o", 32'(ready_o), 32'd0);
      check("stall_ALUCtrl", 32'(ALUCtrl_o), 32'b011);
      check("stall_valid", 32'(valid_o), 32'd1);
    end
    cycle(32'h402081B3, 1'b1, 1'b0, 1'b1, acc);
    check("flush_valid", 32'(valid_o), 32'd0);
    check("flush_RegWrite", 32'(RegWrite_o), 32'd0);
    cycle(32'h0, 1'b0, 1'b1, 1'b0, acc);
    check("post_flush_valid", 32'(valid_o), 32'd0);

    cycle(32'h002081B3, 1'b1, 1'b1, 1'b0, acc);
    cycle(32'h402081B3, 1'b1, 1'b0, 1'b0, acc);
    reset_mid_cycle();

    pend = 1'b0;
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        reset_mid_cycle();
        pend = 1'b0;
      end
      if (!pend) cur = gen_inst();
      cycle(cur, pend ? 1'b1 : ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 31) == 0), acc);
      pend = valid_i & ~acc & ~flush_i;
    end
    cycle(32'h0, 1'b0, 1'b1, 1'b0, acc);
`ifdef ALU_DECODE_PERF_EN
    check("decoded_cnt", decoded_cnt, 32'(exp_dec));
    check("illegal_cnt", illegal_cnt, 32'(exp_ill));
`endif
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decode_stage.md
# alu_ctrl_decode_stage

Registered decode stage that turns a 32-bit RV32 instruction into the 3-bit ALU control code, operand select, immediate and register indices consumed by the ALU in EX. It sits between the IF/ID and ID/EX boundaries, producing the `ALUCtrl` code the ALU decodes. It holds one decoded instruction behind a valid/ready handshake, with flush and illegal-instruction flagging.

## Interface
Parameters:
- XLEN, 32, instruction and immediate width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- inst_i  in  32  instruction from IF/ID
- valid_i  in  1  inst_i is valid
- ready_o  out  1  stage can accept inst_i this cycle
- flush_i  in  1  discard held and incoming instruction
- valid_o  out  1  decoded outputs are valid
- ready_i  in  1  EX accepts decoded outputs
- ALUCtrl_o  out  3  ALU control code
- ALUSrc_o  out  1  1 = data2 is imm_o, 0 = rs2 value
- RegWrite_o  out  1  write rd in WB
- rs1_o, rs2_o, rd_o  out  5 each  register indices
- imm_o  out  32  sign-extended immediate
- illegal_o  out  1  held instruction is not in the supported set

## Operation
ALU control encoding, with `ALUCtrl_o` being the code EX applies:
- 000 and, 001 xor, 010 sll, 011 add, 100 sub, 101 mul, 110 addi, 111 srai

Supported instructions:
- Opcode 0110011, funct7/funct3:
  - 0000000/111 and
  - 0000000/100 xor
  - 0000000/001 sll
  - 0000000/000 add
  - 0100000/000 sub
  - 0000001/000 mul
- Opcode 0010011:
  - funct3 000 is addi, with imm = sign-extended inst[31:20].
  - funct3 101 with inst[31:25]=0100000 is srai, with imm = zero-extended inst[24:20].
- R-type sets ALUSrc=0 and imm=0. I-type sets ALUSrc=1 and rs2_o=0.
- RegWrite=1 for every legal instruction except when rd=0, where it is forced to 0.
- Any other encoding is illegal:
  - illegal_o=1, ALUCtrl_o=000, ALUSrc_o=0, RegWrite_o=0, imm_o=0.
  - rs1/rs2/rd are still passed through raw.
  - valid_o still asserts so the exception reaches EX.

Handshake:
- ready_o = !valid_o | ready_i (combinational).
- A load happens when valid_i & ready_o.
- Without a load, outputs hold while valid_o & !ready_i. Otherwise valid_o clears on transfer.

Flush:
- flush_i has priority over all other events: next cycle valid_o=0 and no load occurs, even if valid_i & ready_o.
- Data outputs may keep stale values, but RegWrite_o and illegal_o are cleared.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on outputs after edge N.
- Throughput is 1 instruction per cycle when ready_i is held high.
- Reset values: valid_o=0, ALUCtrl_o=000, ALUSrc_o=0, RegWrite_o=0, rs1/rs2/rd=0, imm_o=0, illegal_o=0, counters 0. ready_o=1 follows from valid_o=0.
- Reset asserted mid-operation drops the held instruction immediately, asynchronously.
- Simultaneous transfer-out and load: the new instruction replaces the old one in the same edge with no bubble.
- valid_i high while stalled: the stage does not load, and the upstream holds inst_i.

## Configuration
- ALU_DECODE_PERF_EN adds two 32-bit counters, with ports `decoded_cnt_o` and `illegal_cnt_o`.
  - Each increments on a load of a legal / illegal instruction respectively. A flush in the same cycle blocks the count.
  - Both wrap from 0xFFFFFFFF to 0.
  - Both reset to 0.
- Without the macro these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- The package `alu_ctrl_pkg` holds:
  - the 3-bit ALU code constants (ALU_AND … ALU_SRAI)
  - opcode constants OP_RTYPE=0110011 and OP_ITYPE=0010011
  - funct7 constants
  - a typedef for the decoded bundle
- Sub-module `alu_ctrl_lut` is a purely combinational inst→bundle decode. The stage wraps it with the handshake register.

## Test plan
- add x3,x1,x2 (0x002081B3), ready_i=1 → next cycle: ALUCtrl=011, ALUSrc=0, RegWrite=1, rs1=1, rs2=2, rd=3, valid_o=1.
- sub 0x402081B3, then mul 0x022081B3, back-to-back → codes 100 then 101 on consecutive cycles.
- addi x5,x0,-1 (0xFFF00293) → ALUCtrl=110, ALUSrc=1, imm=0xFFFFFFFF, rd=5. srai x6,x5,3 (0x4032D313) → ALUCtrl=111, imm=0x00000003.
- Illegal 0x0000707F → illegal_o=1, RegWrite=0, valid_o=1. Also addi x0,x0,0 (0x00000013) → RegWrite=0, illegal_o=0.
- Hold ready_i=0 for 3 cycles with valid_i=1 → outputs stable, ready_o=0. Then raise flush_i → valid_o=0 next cycle, new instruction not loaded.
- Assert rst_i mid-stall between edges → valid_o=0 immediately. With ALU_DECODE_PERF_EN, counters read 0.
